result_monitor: RTL and testbench
=================================

Name: result_monitor

Overview:
Parametrised, self-checking result monitor for CPU regression runs. It snoops the memory write bus and captures writes to up to NUM_CH configurable addresses. At the end of a bounded run window it compares each capture against an expected byte and reports per-channel and overall pass/fail. It replaces fixed-delay, single-address end-of-test checks with a multi-channel, timeout-bounded, two-mode checker that can sit beside the memory model in top.

Parameters:
ADDR_WIDTH, 16, width of the snooped write address
DATA_WIDTH, 8, width of the snooped write data
NUM_CH, 4, number of independent check channels (1..16)
CNT_W, 16, width of the run-window cycle counter and timeout

Ports:
ph2  input  1  single clock; all state updates on its rising edge
reset  input  1  synchronous, active-high reset
start  input  1  one-cycle pulse; latches configuration and begins a run
timeout  input  CNT_W  run length in ph2 cycles; sampled on start
mode  input  1  0 = last-write-wins, 1 = first-write-only with early finish; sampled on start
ch_en  input  NUM_CH  per-channel enable; sampled on start
ch_addr  input  NUM_CH*ADDR_WIDTH  channel i watch address at bits [i*ADDR_WIDTH +: ADDR_WIDTH]; sampled on start
ch_exp  input  NUM_CH*DATA_WIDTH  channel i expected value, packed the same way; sampled on start
wr_en  input  1  memory write strobe for the current cycle
wr_addr  input  ADDR_WIDTH  write address
wr_data  input  DATA_WIDTH  write data
busy  output  1  high while in RUN
done  output  1  high while in DONE
pass  output  1  valid while done
hit_mask  output  NUM_CH  channel captured at least one write
fail_mask  output  NUM_CH  per-channel failure, valid while done
cycles  output  CNT_W  RUN cycles elapsed in the current or last run

Behaviour:
- Reset (synchronous, ph2 edge with reset=1): state IDLE. busy, done, pass, hit_mask, fail_mask and cycles are all 0. Latched configuration and capture registers are cleared. Reset overrides start and aborts any run in progress.
- States:
  - IDLE: start=1 latches timeout, mode, ch_en, ch_addr and ch_exp. It also clears captures, hit_mask and cycles. Next state is RUN, or DONE if the latched timeout is 0.
  - RUN: busy=1. Each cycle, cycles increments (saturates at all-ones). The run ends after exactly timeout RUN cycles: when cycles==timeout-1 in the current cycle, the next state is DONE. start is ignored.
  - DONE: done=1. Outputs hold until start or reset. start=1 behaves exactly as in IDLE.
- Capture happens only in RUN. A channel i matches when wr_en=1, ch_en_l[i]=1 and wr_addr==ch_addr_l[i]. On a match:
  - mode 0: capture[i] takes wr_data on every match (last write wins); hit_mask[i] is set.
  - mode 1: capture[i] takes wr_data only if hit_mask[i]=0; later writes to that address are ignored.
- Several channels may watch the same address; each captures independently from the same write.
- Early finish (mode 1 only): if every enabled channel is hit after this cycle's capture, the next state is DONE regardless of remaining timeout. This includes the cycle in which the last hit occurs.
- A write that arrives in the same cycle as the timeout-ending cycle is captured.
- Writes in IDLE, in DONE, or in the start cycle are ignored.
- Evaluation is registered on entry to DONE, so it is valid in the first cycle done=1:
  - fail_mask[i] = ch_en_l[i] & (~hit[i] | capture[i] != ch_exp_l[i]).
  - pass = (ch_en_l != 0) & (fail_mask == 0).
  - With no channel enabled, pass is 0 and fail_mask is 0.
- Latency: done rises one ph2 cycle after the RUN cycle that ends the run. With timeout=T and no early finish, done rises T+1 cycles after the start cycle.
- Configuration inputs may change freely after start; only the latched copies are used.

Test Plan:
- Basic pass, single channel: mode 0, ch_en=0001, ch_addr0=0x0071, ch_exp0=0xFF, timeout=140; write 0x0071<-0xFE at RUN cycle 10 and 0x0071<-0xFF at cycle 50 -> done at cycle 141 after start, pass=1, fail_mask=0, hit_mask=0001, cycles=140.
- Mismatch and miss: 4 channels enabled; channel 1 receives the wrong value 0x12 (expected 0x34); channel 3 is never written -> pass=0, fail_mask=1010, hit_mask=0111.
- Early finish: mode 1, channels 0 and 2 enabled, timeout=1000; writes hit both channels by RUN cycle 20 -> done one cycle after cycle 20, cycles=21. A later repeat write to channel 0 in a mode-1 run is not recaptured.
- Boundary timing: timeout=0 -> DONE one cycle after start, pass=0. A write on RUN cycle timeout-1 is captured; a write on the start cycle or while done is ignored.
- Reset and restart: assert reset mid-RUN -> next cycle all outputs 0, state IDLE. Issue start in DONE with new config -> hit_mask and cycles clear, new run proceeds. start pulses during RUN have no effect.
- Aliased channels: channels 0 and 1 both watch 0x0200 with expected 0xAA and 0xBB; write 0xAA -> fail_mask=0010.

Source files
------------

// File: rtl/result_monitor.sv
// result_monitor: multi-channel memory-write snooper with bounded run window and registered pass/fail evaluation
module result_monitor #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8,
  parameter int NUM_CH     = 4,
  parameter int CNT_W      = 16
) (
  input  logic                         ph2,
  input  logic                         reset,
  input  logic                         start,
  input  logic [CNT_W-1:0]             timeout,
  input  logic                         mode,
  input  logic [NUM_CH-1:0]            ch_en,
  input  logic [NUM_CH*ADDR_WIDTH-1:0] ch_addr,
  input  logic [NUM_CH*DATA_WIDTH-1:0] ch_exp,
  input  logic                         wr_en,
  input  logic [ADDR_WIDTH-1:0]        wr_addr,
  input  logic [DATA_WIDTH-1:0]        wr_data,
  output logic                         busy,
  output logic                         done,
  output logic                         pass,
  output logic [NUM_CH-1:0]            hit_mask,
  output logic [NUM_CH-1:0]            fail_mask,
  output logic [CNT_W-1:0]             cycles
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic [CNT_W-1:0] tmo_q, tmo_d, cyc_q, cyc_d;
  logic mode_q, mode_d, pass_q, pass_d;
  logic [NUM_CH-1:0] en_q, en_d, hit_q, hit_d, fail_q, fail_d, fail_n;
  logic [NUM_CH*ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [NUM_CH*DATA_WIDTH-1:0] exp_q, exp_d, cap_q, cap_d;
  logic launch, run, last, all_hit, eval;
  assign run     = state_q == RUN;
  assign launch  = start && !run;
  assign last    = cyc_q == tmo_q - 1'b1;
  assign all_hit = en_q != '0 && (hit_d & en_q) == en_q;
  assign eval    = state_d == DONE && (run || launch);
  always_comb begin
    tmo_d  = launch ? timeout : tmo_q;
    mode_d = launch ? mode : mode_q;
    en_d   = launch ? ch_en : en_q;
    addr_d = launch ? ch_addr : addr_q;
    exp_d  = launch ? ch_exp : exp_q;
    cyc_d  = launch ? '0 : (run && !(&cyc_q)) ? cyc_q + 1'b1 : cyc_q;
  end
  always_comb begin
    hit_d = launch ? '0 : hit_q;
    cap_d = launch ? '0 : cap_q;
    for (int i = 0; i < NUM_CH; i++)
      if (run && wr_en && en_q[i] && wr_addr == addr_q[i*ADDR_WIDTH +: ADDR_WIDTH] && !(mode_q && hit_q[i])) begin
        cap_d[i*DATA_WIDTH +: DATA_WIDTH] = wr_data;
        hit_d[i] = 1'b1;
      end
  end
  always_comb begin
    fail_n = '0;
    for (int i = 0; i < NUM_CH; i++)
      fail_n[i] = en_d[i] & (~hit_d[i] | (cap_d[i*DATA_WIDTH +: DATA_WIDTH] != exp_d[i*DATA_WIDTH +: DATA_WIDTH]));
    fail_d = eval ? fail_n : launch ? '0 : fail_q;
    pass_d = eval ? (en_d != '0 && fail_n == '0) : launch ? 1'b0 : pass_q;
  end
  always_comb
    state_d = launch ? (timeout == '0 ? DONE : RUN) :
              (run && (last || (mode_q && all_hit))) ? DONE : state_q;
  always_ff @(posedge ph2)
    state_q <= reset ? IDLE : state_d;
  always_comb begin
    busy = state_q == RUN;
    done = state_q == DONE;
  end
  always_ff @(posedge ph2) begin
    if (reset) begin
      tmo_q  <= '0;
      cyc_q  <= '0;
      mode_q <= 1'b0;
      en_q   <= '0;
      addr_q <= '0;
      exp_q  <= '0;
      hit_q  <= '0;
      cap_q  <= '0;
      fail_q <= '0;
      pass_q <= 1'b0;
    end else begin
      tmo_q  <= tmo_d;
      cyc_q  <= cyc_d;
      mode_q <= mode_d;
      en_q   <= en_d;
      addr_q <= addr_d;
      exp_q  <= exp_d;
      hit_q  <= hit_d;
      cap_q  <= cap_d;
      fail_q <= fail_d;
      pass_q <= pass_d;
    end
  end
  assign pass      = pass_q;
  assign hit_mask  = hit_q;
  assign fail_mask = fail_q;
  assign cycles    = cyc_q;
endmodule

// File: tb/tb_result_monitor.sv
// tb_result_monitor: directed-vector self-checking bench for result_monitor
module tb_result_monitor;
  logic ph2 = 1'b0, reset, start, mode, wr_en;
  logic [15:0] timeout, wr_addr;
  logic [3:0] ch_en;
  logic [63:0] ch_addr;
  logic [31:0] ch_exp;
  logic [7:0] wr_data;
  logic busy, done, pass;
  logic [3:0] hit_mask, fail_mask;
  logic [15:0] cycles;
  int n_run = 0, n_fail = 0;
  result_monitor dut (
    .ph2(ph2), .reset(reset), .start(start), .timeout(timeout), .mode(mode),
    .ch_en(ch_en), .ch_addr(ch_addr), .ch_exp(ch_exp), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy), .done(done), .pass(pass),
    .hit_mask(hit_mask), .fail_mask(fail_mask), .cycles(cycles)
  );
  always #5 ph2 = ~ph2;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge ph2);
    #1;
  endtask
  task automatic idle(input int n);
    repeat (n) tick();
  endtask
  task automatic cfg(input int i, input logic [15:0] a, input logic [7:0] e);
    ch_addr[i*16 +: 16] = a;
    ch_exp[i*8 +: 8] = e;
  endtask
  task automatic go(input logic [15:0] t, input logic m, input logic [3:0] en);
    timeout = t;
    mode = m;
    ch_en = en;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask
  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    wr_en = 1'b1;
    wr_addr = a;
    wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask
  task automatic check_end(input string tag, input logic p, input logic [3:0] f, input logic [3:0] h, input logic [15:0] c);
    chk({tag, "_done"}, done, 1'b1);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_pass"}, pass, p);
    chk({tag, "_fail"}, fail_mask, f);
    chk({tag, "_hit"}, hit_mask, h);
    chk({tag, "_cycles"}, cycles, c);
  endtask
  initial begin
    reset = 1'b1; start = 1'b0; mode = 1'b0; wr_en = 1'b0; timeout = '0;
    wr_addr = '0; wr_data = '0; ch_en = '0; ch_addr = '0; ch_exp = '0;
    idle(2);
    reset = 1'b0;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_pass", pass, 1'b0);
    chk("rst_hit", hit_mask, 4'h0);
    chk("rst_fail", fail_mask, 4'h0);
    chk("rst_cycles", cycles, 16'd0);
    cfg(0, 16'h0071, 8'hFF);
    go(16'd140, 1'b0, 4'b0001);
    ch_exp = '0; ch_addr = '0; timeout = 16'd3; mode = 1'b1;
    chk("t1_busy", busy, 1'b1);
    idle(10);
    wr(16'h0071, 8'hFE);
    idle(39);
    wr(16'h0071, 8'hFF);
    idle(88);
    chk("t1_early_done", done, 1'b0);
    tick();
    check_end("t1", 1'b1, 4'h0, 4'b0001, 16'd140);
    wr(16'h0071, 8'h00);
    chk("t1_hold_pass", pass, 1'b1);
    cfg(0, 16'h0100, 8'h11); cfg(1, 16'h0101, 8'h34);
    cfg(2, 16'h0102, 8'h56); cfg(3, 16'h0103, 8'h78);
    wr_en = 1'b1; wr_addr = 16'h0103; wr_data = 8'h78;
    go(16'd20, 1'b0, 4'b1111);
    wr_en = 1'b0;
    chk("t2_hit_clr", hit_mask, 4'h0);
    chk("t2_cyc_clr", cycles, 16'd0);
    chk("t2_busy", busy, 1'b1);
    wr(16'h0100, 8'h11);
    wr(16'h0101, 8'h12);
    wr(16'h0102, 8'h56);
    start = 1'b1; timeout = 16'd2; tick(); start = 1'b0;
    chk("t2_start_ign", cycles, 16'd4);
    idle(16);
    check_end("t2", 1'b0, 4'b1010, 4'b0111, 16'd20);
    cfg(0, 16'h0300, 8'h5A); cfg(2, 16'h0302, 8'hA5);
    go(16'd1000, 1'b1, 4'b0101);
    wr(16'h0300, 8'h5A);
    wr(16'h0300, 8'h00);
    idle(18);
    wr(16'h0302, 8'hA5);
    check_end("t3", 1'b1, 4'h0, 4'b0101, 16'd21);
    go(16'd0, 1'b0, 4'b0001);
    check_end("t4z", 1'b0, 4'b0001, 4'h0, 16'd0);
    cfg(0, 16'h0400, 8'h77);
    go(16'd5, 1'b0, 4'b0001);
    idle(4);
    chk("t4_busy", busy, 1'b1);
    wr(16'h0400, 8'h77);
    check_end("t4b", 1'b1, 4'h0, 4'b0001, 16'd5);
    cfg(0, 16'h0500, 8'h01);
    go(16'd50, 1'b0, 4'b0001);
    wr(16'h0500, 8'h01);
    chk("t5_hit_pre", hit_mask, 4'b0001);
    reset = 1'b1; tick(); reset = 1'b0;
    chk("t5_busy", busy, 1'b0);
    chk("t5_done", done, 1'b0);
    chk("t5_hit", hit_mask, 4'h0);
    chk("t5_cycles", cycles, 16'd0);
    tick();
    chk("t5_idle", busy, 1'b0);
    cfg(0, 16'h0200, 8'hAA); cfg(1, 16'h0200, 8'hBB);
    go(16'd3, 1'b0, 4'b0011);
    wr(16'h0200, 8'hAA);
    idle(1);
    chk("t6_early_done", done, 1'b0);
    tick();
    check_end("t6", 1'b0, 4'b0010, 4'b0011, 16'd3);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
